// File: rtl/ecg_sample_uart_tx.sv
// ecg_sample_uart_tx: captures 12-bit ADC samples on dv rising edges into a FIFO and streams each as a tagged 2-byte UART 8N1 frame
//   clk        : system clock
//   rst        : synchronous active-high reset
//   data       : 12-bit ADC sample, stable while dv is high
//   dv         : sample-valid level; only its rising edge captures
//   tx         : registered UART serial out, idle high
//   busy       : serializer active or samples queued
//   overflow   : sticky, a sample arrived while the FIFO was full
//   fifo_level : number of samples currently queued
module ecg_sample_uart_tx #(
  parameter real FCLK       = 100e6,
  parameter real BAUD       = 115200.0,
  parameter int  FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [11:0]                      data,
  input  logic                             dv,
  output logic                             tx,
  output logic                             busy,
  output logic                             overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);
  localparam int CPB = $rtoi(FCLK / BAUD);
  localparam int CW  = $clog2(CPB);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic          sel_q, sel_d;
  logic [15:0]   frame_q, frame_d;
  logic          tx_q, tx_d;
  logic          dv_q, ovf_q;
  logic [11:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q;
  logic          push, pop, full, wr_en, last;
  logic [7:0]    cur_byte;
  assign push     = dv & ~dv_q;
  assign full     = level_q == LW'(FIFO_DEPTH);
  assign pop      = (state_q == IDLE) & (level_q != '0);
  // a full FIFO still accepts the sample when the serializer pops in the same cycle
  assign wr_en    = push & (~full | pop);
  assign last     = cnt_q == CW'(CPB - 1);
  assign cur_byte = sel_q ? frame_q[7:0] : frame_q[15:8];
  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) | (level_q != '0);
  assign overflow   = ovf_q;
  assign fifo_level = level_q;
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sel_d   = sel_q;
    frame_d = frame_q;
    cnt_d   = (state_q == IDLE || last) ? '0 : cnt_q + 1'b1;
    // tx follows the current state one cycle later, keeping every bit exactly CPB cycles wide
    tx_d    = state_q == START ? 1'b0 : state_q == DATA ? cur_byte[bit_q] : 1'b1;
    case (state_q)
      IDLE: if (pop) begin
        frame_d = {4'hA, mem_q[rd_q]};
        sel_d   = 1'b0;
        state_d = START;
      end
      START: if (last) begin
        bit_d   = '0;
        state_d = DATA;
      end
      DATA: if (last) begin
        bit_d   = bit_q + 1'b1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (last) begin
        sel_d   = 1'b1;
        state_d = sel_q ? IDLE : START;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sel_q   <= 1'b0;
      frame_q <= '0;
      tx_q    <= 1'b1;
      dv_q    <= 1'b1;
      ovf_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sel_q   <= sel_d;
      frame_q <= frame_d;
      tx_q    <= tx_d;
      dv_q    <= dv;
      ovf_q   <= ovf_q | (push & full & ~pop);
      wr_q    <= wr_en ? wr_q + 1'b1 : wr_q;
      rd_q    <= pop ? rd_q + 1'b1 : rd_q;
      level_q <= level_q + LW'(wr_en) - LW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= data;
  end
endmodule

// File: tb/tb_ecg_sample_uart_tx.sv
// tb_ecg_sample_uart_tx: randomized scoreboard bench with a timing-level reference model and a UART decoding monitor
module tb_ecg_sample_uart_tx;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 20 * CPB;
  logic clk = 1'b0, rst = 1'b1, dv = 1'b0;
  logic [11:0] data = '0;
  logic tx, busy, overflow;
  logic [2:0] fifo_level;
  typedef struct {logic [7:0] b; int t;} exp_t;
  exp_t exp_q[$];
  logic [11:0] pend[$];
  exp_t mx;
  logic [11:0] md;
  int cyc = 0, next_pop = 0, rst_gen = 0, seen_gen = 0, m_level = 0;
  int nbytes = 0, lvl_max = 0, total = 0, bad = 0;
  int off = 0, st_cyc = 0;
  logic dv_prev = 1'b1, m_ovf = 1'b0, m_busy = 1'b0, mon_en = 1'b0;
  logic dec_on = 1'b0, cur = 1'b1, stable = 1'b1;
  logic [9:0] sh = '0;

  ecg_sample_uart_tx #(.FCLK(1.6e6), .BAUD(1.0e5), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .data(data), .dv(dv), .tx(tx),
    .busy(busy), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // reference model: FIFO as a queue, serializer as "next pop allowed at" cycle arithmetic
  initial forever begin
    @(posedge clk);
    if (rst) begin
      pend.delete();
      exp_q.delete();
      next_pop = 0;
      m_ovf = 1'b0;
      dv_prev = 1'b1;
      rst_gen++;
    end else begin
      if (pend.size() > 0 && cyc >= next_pop) begin
        md = pend.pop_front();
        mx.b = {4'hA, md[11:8]};
        mx.t = cyc + 2;
        exp_q.push_back(mx);
        mx.b = md[7:0];
        mx.t = cyc + 2 + 10 * CPB;
        exp_q.push_back(mx);
        next_pop = cyc + FRAME + 1;
      end
      if (dv && !dv_prev) begin
        if (pend.size() < DEPTH) pend.push_back(data);
        else m_ovf = 1'b1;
      end
      dv_prev = dv;
    end
    m_level = pend.size();
    m_busy = pend.size() > 0 || cyc < next_pop - 1;
    cyc++;
  end

  // monitor: status compare every cycle, UART byte decode against the scoreboard
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("level", fifo_level, m_level);
      chk("overflow", overflow, m_ovf);
      chk("busy", busy, m_busy);
      if (int'(fifo_level) > lvl_max) lvl_max = fifo_level;
    end
    if (rst_gen != seen_gen) begin
      seen_gen = rst_gen;
      dec_on = 1'b0;
    end else begin
      if (!dec_on && tx === 1'b0) begin
        dec_on = 1'b1;
        off = 0;
        st_cyc = cyc;
        stable = 1'b1;
      end
      if (dec_on) begin
        if (off % CPB == 0) cur = tx;
        else if (tx !== cur) stable = 1'b0;
        if (off % CPB == CPB - 1) sh[off / CPB] = cur;
        if (off == 10 * CPB - 1) begin
          dec_on = 1'b0;
          nbytes++;
          if (exp_q.size() == 0) chk("unexpected_byte", exp_q.size(), 1);
          else begin
            mx = exp_q.pop_front();
            chk("byte", sh[8:1], mx.b);
            chk("start_cycle", st_cyc, mx.t);
            chk("framing", {sh[0], sh[9], stable}, 3'b011);
          end
        end
        off++;
      end
    end
  end

  task automatic pulse(input logic [11:0] d, input int h, input int g);
    data = d;
    dv = 1'b1;
    repeat (h) @(negedge clk);
    dv = 1'b0;
    repeat (g) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() > 0 || m_busy || pend.size() > 0) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", n < 30000, 1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int b0, n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_level", fifo_level, 0);
    chk("reset_busy", busy, 0);
    chk("reset_overflow", overflow, 0);
    // single sample
    b0 = nbytes;
    data = 12'hABC;
    dv = 1'b1;
    @(negedge clk);
    chk("single_tx_e1", tx, 1);
    @(negedge clk);
    chk("single_tx_e2", tx, 1);
    @(negedge clk);
    chk("single_tx_low", tx, 0);
    repeat (97) @(negedge clk);
    dv = 1'b0;
    drain();
    chk("single_bytes", nbytes - b0, 2);
    chk("single_busy", busy, 0);
    // back-to-back
    b0 = nbytes;
    lvl_max = 0;
    pulse(12'h001, 2, 3);
    pulse(12'h7FF, 2, 3);
    pulse(12'hFFF, 2, 3);
    drain();
    chk("b2b_peak", lvl_max, 2);
    chk("b2b_bytes", nbytes - b0, 6);
    chk("b2b_overflow", overflow, 0);
    // overflow
    b0 = nbytes;
    for (int i = 1; i <= 6; i++) pulse(12'(i), 4, 4);
    chk("ovf_level", fifo_level, 4);
    chk("ovf_flag", overflow, 1);
    drain();
    chk("ovf_bytes", nbytes - b0, 10);
    chk("ovf_sticky", overflow, 1);
    // full push + pop in the same cycle
    do_reset();
    for (int i = 0; i < 5; i++) pulse(12'h300 + 12'(i), 2, 2);
    chk("full_level", fifo_level, 4);
    n = 0;
    while (cyc != next_pop && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("align_timeout", n < 2000, 1);
    data = 12'h5A5;
    dv = 1'b1;
    @(negedge clk);
    chk("pushpop_level", fifo_level, 4);
    chk("pushpop_overflow", overflow, 0);
    dv = 1'b0;
    drain();
    // reset mid-frame
    for (int i = 0; i < 3; i++) pulse(12'h900 + 12'(i), 2, 2);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_tx", tx, 1);
    chk("midrst_level", fifo_level, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_overflow", overflow, 0);
    b0 = nbytes;
    repeat (400) @(negedge clk);
    chk("midrst_quiet", nbytes - b0, 0);
    // reset released with dv high
    data = 12'h123;
    dv = 1'b1;
    do_reset();
    repeat (50) @(negedge clk);
    chk("dvhigh_tx", tx, 1);
    chk("dvhigh_level", fifo_level, 0);
    b0 = nbytes;
    dv = 1'b0;
    repeat (5) @(negedge clk);
    pulse(12'h123, 10, 2);
    drain();
    chk("dvhigh_bytes", nbytes - b0, 2);
    // randomized traffic
    for (int i = 0; i < 40; i++)
      pulse(12'($urandom_range(0, 4095)), $urandom_range(1, 20),
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : $urandom_range(20, 700));
    drain();
    chk("final_queue", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
